// File: rtl/fp_add_pipe.sv
// Fully pipelined floating-point adder/subtractor with round-to-nearest-even.
// Register ranks: align -> add/sub -> normalise -> round/pack, so a result appears three enabled edges after its operands are sampled.
module fp_add_pipe #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                 clk,
   input  logic                 n_reset,
   input  logic                 clk_en,
   input  logic                 in_valid,
   input  logic                 op_sub,
   input  logic [EXP_W+MAN_W:0] a,
   input  logic [EXP_W+MAN_W:0] b,
   output logic                 out_valid,
   output logic [EXP_W+MAN_W:0] result,
   output logic                 ovf,
   output logic                 unf,
   output logic                 inexact,
   output logic                 invalid
);
   localparam int W    = 1 + EXP_W + MAN_W;
   localparam int F    = MAN_W + 4;
   localparam int S    = MAN_W + 5;
   localparam int EMAX = (1 << EXP_W) - 1;
   localparam logic [EXP_W-1:0] E_ONES = {EXP_W{1'b1}};
   localparam logic [EXP_W-1:0] E_ZERO = {EXP_W{1'b0}};
   localparam logic [MAN_W-1:0] M_ZERO = {MAN_W{1'b0}};
   localparam logic [W-1:0]     C_NAN  = {1'b0, E_ONES, 1'b1, {(MAN_W-1){1'b0}}};

   // MSB-seek priority encoder: number of leading zeros in the mantissa field
   function automatic int lzc(input logic [F-1:0] v);
      int pos;
      pos = -1;
      for (int i = 0; i < F; i++) begin
         if (v[i]) pos = i;
         else      pos = pos;
      end
      return F - 1 - pos;
   endfunction

   logic             sa_s, sb_s, sx_s, sy_s, za_s, zb_s, zx_s, zy_s;
   logic             ia_s, ib_s, na_s, nb_s, swap_s, inv_s, spec_s;
   logic [EXP_W-1:0] ea_s, eb_s, ex_s, ey_s, d_s;
   logic [MAN_W-1:0] fa_s, fb_s, fx_s, fy_s;
   logic [W-2:0]     ka_s, kb_s;
   logic [F-1:0]     mx_s, my_s;
   logic [2*F-1:0]   wide_s;
   logic [W-1:0]     spec_res_s;

   // Decode, order by magnitude and align the smaller operand (G/R/S kept below the LSB)
   always_comb begin
      sa_s   = a[W-1];
      sb_s   = b[W-1] ^ op_sub;
      ea_s   = a[W-2:MAN_W];
      eb_s   = b[W-2:MAN_W];
      fa_s   = a[MAN_W-1:0];
      fb_s   = b[MAN_W-1:0];
      za_s   = (ea_s == E_ZERO);
      zb_s   = (eb_s == E_ZERO);
      ia_s   = (ea_s == E_ONES) && (fa_s == M_ZERO);
      ib_s   = (eb_s == E_ONES) && (fb_s == M_ZERO);
      na_s   = (ea_s == E_ONES) && (fa_s != M_ZERO);
      nb_s   = (eb_s == E_ONES) && (fb_s != M_ZERO);
      ka_s   = za_s ? {(W-1){1'b0}} : a[W-2:0];
      kb_s   = zb_s ? {(W-1){1'b0}} : b[W-2:0];
      swap_s = (kb_s > ka_s);
      sx_s   = swap_s ? sb_s : sa_s;
      sy_s   = swap_s ? sa_s : sb_s;
      ex_s   = swap_s ? eb_s : ea_s;
      ey_s   = swap_s ? ea_s : eb_s;
      fx_s   = swap_s ? fb_s : fa_s;
      fy_s   = swap_s ? fa_s : fb_s;
      zx_s   = swap_s ? zb_s : za_s;
      zy_s   = swap_s ? za_s : zb_s;
      d_s    = ex_s - ey_s;
      mx_s   = zx_s ? {F{1'b0}} : {1'b1, fx_s, 3'b000};
      wide_s = {1'b1, fy_s, 3'b000, {F{1'b0}}} >> d_s;
      if (zy_s) begin
         my_s = {F{1'b0}};
      end else if (int'(d_s) >= MAN_W + 3) begin
         my_s = {{(F-1){1'b0}}, 1'b1};
      end else begin
         my_s = {wide_s[2*F-1:F+1], wide_s[F] | (|wide_s[F-1:0])};
      end
      inv_s      = na_s | nb_s | (ia_s & ib_s & (sa_s ^ sb_s));
      spec_s     = na_s | nb_s | ia_s | ib_s;
      spec_res_s = inv_s ? C_NAN : {sx_s, E_ONES, M_ZERO};
   end

   logic             v1_r, sx1_r, sub1_r, spec1_r, inv1_r, zs1_r;
   logic [EXP_W-1:0] ex1_r;
   logic [F-1:0]     mx1_r, my1_r;
   logic [W-1:0]     sres1_r;

   // Align-stage register
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         v1_r <= 1'b0; sx1_r <= 1'b0; sub1_r <= 1'b0; spec1_r <= 1'b0; inv1_r <= 1'b0; zs1_r <= 1'b0;
         ex1_r <= E_ZERO; mx1_r <= {F{1'b0}}; my1_r <= {F{1'b0}}; sres1_r <= {W{1'b0}};
      end else if (clk_en) begin
         v1_r <= in_valid; sx1_r <= sx_s; sub1_r <= sx_s ^ sy_s; spec1_r <= spec_s; inv1_r <= inv_s;
         zs1_r <= sa_s & sb_s; ex1_r <= ex_s; mx1_r <= mx_s; my1_r <= my_s; sres1_r <= spec_res_s;
      end
   end

   logic [S-1:0]     sum_s, sum2_r;
   logic             v2_r, sx2_r, spec2_r, inv2_r, zs2_r;
   logic [EXP_W-1:0] ex2_r;
   logic [W-1:0]     sres2_r;

   // Magnitude add or subtract; X is never smaller than Y so the difference is non-negative
   always_comb begin
      if (sub1_r) sum_s = {1'b0, mx1_r} - {1'b0, my1_r};
      else        sum_s = {1'b0, mx1_r} + {1'b0, my1_r};
   end

   // Add-stage register
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         v2_r <= 1'b0; sx2_r <= 1'b0; spec2_r <= 1'b0; inv2_r <= 1'b0; zs2_r <= 1'b0;
         ex2_r <= E_ZERO; sum2_r <= {S{1'b0}}; sres2_r <= {W{1'b0}};
      end else if (clk_en) begin
         v2_r <= v1_r; sx2_r <= sx1_r; spec2_r <= spec1_r; inv2_r <= inv1_r; zs2_r <= zs1_r;
         ex2_r <= ex1_r; sum2_r <= sum_s; sres2_r <= sres1_r;
      end
   end

   int                 lz_s, ex_int_s;
   logic [F-1:0]       norm_s;
   logic signed [31:0] en_s;

   // Normalise: one right shift on carry-out, otherwise left shift by leading-zero count
   always_comb begin
      lz_s     = lzc(sum2_r[F-1:0]);
      ex_int_s = int'(ex2_r);
      if (sum2_r[S-1]) begin
         norm_s = {sum2_r[S-1:2], sum2_r[1] | sum2_r[0]};
         en_s   = ex_int_s + 32'sd1;
      end else begin
         norm_s = sum2_r[F-1:0] << lz_s;
         en_s   = ex_int_s - lz_s;
      end
   end

   logic               v3_r, sx3_r, z3_r, spec3_r, inv3_r, zs3_r;
   logic signed [31:0] e3_r;
   logic [F-2:0]       m3_r;
   logic [W-1:0]       sres3_r;

   // Normalise-stage register; a cleared hidden bit after normalising means an exact zero
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         v3_r <= 1'b0; sx3_r <= 1'b0; z3_r <= 1'b0; spec3_r <= 1'b0; inv3_r <= 1'b0; zs3_r <= 1'b0;
         e3_r <= 32'sd0; m3_r <= {(F-1){1'b0}}; sres3_r <= {W{1'b0}};
      end else if (clk_en) begin
         v3_r <= v2_r; sx3_r <= sx2_r; z3_r <= ~norm_s[F-1]; spec3_r <= spec2_r; inv3_r <= inv2_r;
         zs3_r <= zs2_r; e3_r <= en_s; m3_r <= norm_s[F-2:0]; sres3_r <= sres2_r;
      end
   end

   logic               inc_s, rc_s;
   logic [MAN_W:0]     rnd_s;
   logic signed [31:0] ef_s;
   logic               ov_n, ovf_n, unf_n, inx_n, inv_n;
   logic [W-1:0]       res_n;

   // Round to nearest even, then resolve exponent range and special results
   always_comb begin
      inc_s = m3_r[2] & (m3_r[1] | m3_r[0] | m3_r[3]);
      rnd_s = {1'b0, m3_r[F-2:3]} + {{MAN_W{1'b0}}, inc_s};
      rc_s  = rnd_s[MAN_W];
      ef_s  = e3_r + (rc_s ? 32'sd1 : 32'sd0);
      ov_n  = v3_r;
      ovf_n = 1'b0;
      unf_n = 1'b0;
      inx_n = 1'b0;
      inv_n = 1'b0;
      res_n = {W{1'b0}};
      if (!v3_r) begin
         ov_n = 1'b0;
      end else if (spec3_r) begin
         res_n = sres3_r;
         inv_n = inv3_r;
      end else if (z3_r) begin
         res_n = {zs3_r, {(W-1){1'b0}}};
      end else if (ef_s >= EMAX) begin
         res_n = {sx3_r, E_ONES, M_ZERO};
         ovf_n = 1'b1;
         inx_n = 1'b1;
      end else if (ef_s <= 32'sd0) begin
         res_n = {sx3_r, {(W-1){1'b0}}};
         unf_n = 1'b1;
         inx_n = 1'b1;
      end else begin
         res_n = {sx3_r, ef_s[EXP_W-1:0], rc_s ? M_ZERO : rnd_s[MAN_W-1:0]};
         inx_n = |m3_r[2:0];
      end
   end

   // Output register
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         out_valid <= 1'b0; result <= {W{1'b0}}; ovf <= 1'b0; unf <= 1'b0; inexact <= 1'b0; invalid <= 1'b0;
      end else if (clk_en) begin
         out_valid <= ov_n; result <= res_n; ovf <= ovf_n; unf <= unf_n; inexact <= inx_n; invalid <= inv_n;
      end
   end
endmodule

// File: tb/tb_fp_add_pipe.sv
// Scoreboard bench for fp_add_pipe: directed single-precision vectors with stalls, bubbles and
// a mid-flight reset, plus a half-precision instance for the parameterised path.
module tb_fp_add_pipe;
   logic        clk, n_reset, clk_en, in_valid, op_sub;
   logic [31:0] a, b, result;
   logic        out_valid, ovf, unf, inexact, invalid;
   logic        h_valid, h_sub, h_ov, h_ovf, h_unf, h_inx, h_inv;
   logic [15:0] h_a, h_b, h_res;

   fp_add_pipe #(.EXP_W(8), .MAN_W(23)) dut (
      .clk(clk), .n_reset(n_reset), .clk_en(clk_en), .in_valid(in_valid), .op_sub(op_sub),
      .a(a), .b(b), .out_valid(out_valid), .result(result), .ovf(ovf), .unf(unf),
      .inexact(inexact), .invalid(invalid));

   fp_add_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (
      .clk(clk), .n_reset(n_reset), .clk_en(clk_en), .in_valid(h_valid), .op_sub(h_sub),
      .a(h_a), .b(h_b), .out_valid(h_ov), .result(h_res), .ovf(h_ovf), .unf(h_unf),
      .inexact(h_inx), .invalid(h_inv));

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic        sub;
      logic [31:0] res;
      logic [3:0]  fl;   // {ovf, unf, inexact, invalid}
   } vec_t;

   typedef struct packed {
      logic [31:0] res;
      logic [3:0]  fl;
      int          id;
      int          due;
   } exp_t;

   vec_t        vecs[$];
   exp_t        sb[$];
   int          n_cmp = 0;
   int          n_fail = 0;
   int          edge_idx = 0;
   logic [36:0] last_exp = 37'd0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string nm, input logic [36:0] got, input logic [36:0] req);
      n_cmp++;
      if (got !== req) begin
         n_fail++;
         $display("FAIL %s: got %h required %h ({valid,ovf,unf,inexact,invalid,result})", nm, got, req);
      end
   endtask

   task automatic check_int(input string nm, input int got, input int req);
      n_cmp++;
      if (got != req) begin
         n_fail++;
         $display("FAIL %s: got %0d required %0d", nm, got, req);
      end
   endtask

   // Monitor: on every enabled edge either the head of the scoreboard is due or outputs must be idle
   initial begin
      logic        en_smp, rst_smp;
      logic [36:0] got;
      exp_t        e;
      forever begin
         @(posedge clk);
         en_smp  = clk_en;
         rst_smp = n_reset;
         #1;
         got = {out_valid, ovf, unf, inexact, invalid, result};
         if (!rst_smp || !n_reset) begin
            check("reset_idle", got, 37'd0);
            last_exp = 37'd0;
         end else if (en_smp) begin
            edge_idx++;
            if (sb.size() > 0 && sb[0].due == edge_idx) begin
               e = sb.pop_front();
               last_exp = {1'b1, e.fl, e.res};
               check($sformatf("vec%0d", e.id), got, last_exp);
            end else begin
               last_exp = 37'd0;
               check($sformatf("idle_edge%0d", edge_idx), got, last_exp);
            end
         end else begin
            check($sformatf("stall_hold_edge%0d", edge_idx), got, last_exp);
         end
      end
   end

   task automatic add_vec(input logic [31:0] va, input logic [31:0] vb, input logic vs,
                          input logic [31:0] vr, input logic [3:0] vf);
      vec_t v;
      v.a = va; v.b = vb; v.sub = vs; v.res = vr; v.fl = vf;
      vecs.push_back(v);
   endtask

   task automatic issue(input int i);
      exp_t e;
      @(negedge clk);
      clk_en = 1'b1; in_valid = 1'b1;
      a = vecs[i].a; b = vecs[i].b; op_sub = vecs[i].sub;
      e.res = vecs[i].res; e.fl = vecs[i].fl; e.id = i; e.due = edge_idx + 4;
      sb.push_back(e);
   endtask

   task automatic stall(input int n);
      repeat (n) begin
         @(negedge clk);
         clk_en = 1'b0; in_valid = 1'b1; a = 32'h4B000000; b = 32'h4B000001; op_sub = 1'b0;
      end
   endtask

   task automatic bubble();
      @(negedge clk);
      clk_en = 1'b1; in_valid = 1'b0; a = 32'h3F800000; b = 32'h3F800000;
   endtask

   task automatic drain();
      @(negedge clk);
      clk_en = 1'b1; in_valid = 1'b0;
      for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
      check_int("drain_outstanding", sb.size(), 0);
   endtask

   initial begin
      int cnt;
      n_reset = 1'b1; clk_en = 1'b1; in_valid = 1'b0; op_sub = 1'b0; a = 32'd0; b = 32'd0;
      h_valid = 1'b0; h_sub = 1'b0; h_a = 16'd0; h_b = 16'd0;

      add_vec(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000); // 0: 1+1
      add_vec(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000); // 1: 1-1
      add_vec(32'h3F800001, 32'h3F800000, 1'b1, 32'h34000000, 4'b0000); // 2: 2^-23
      add_vec(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000); // 3: -0 + -0
      add_vec(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0010); // 4: exact tie, even
      add_vec(32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 4'b0010); // 5: above tie
      add_vec(32'h3F800000, 32'h00800000, 1'b0, 32'h3F800000, 4'b0010); // 6: sticky only
      add_vec(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b1010); // 7: overflow
      add_vec(32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b0001); // 8: inf-inf
      add_vec(32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0001); // 9: NaN in
      add_vec(32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'b0000); // 10: inf+finite
      add_vec(32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 4'b0000); // 11: 1-2
      add_vec(32'h40400000, 32'h3F800000, 1'b0, 32'h40800000, 4'b0000); // 12: 3+1 carry
      add_vec(32'h00C00000, 32'h00800000, 1'b1, 32'h00000000, 4'b0110); // 13: underflow
      add_vec(32'h40490FDB, 32'h00000000, 1'b1, 32'h40490FDB, 4'b0000); // 14: x-0
      add_vec(32'h3FFFFFFF, 32'h33800000, 1'b0, 32'h40000000, 4'b0010); // 15: round carry
      add_vec(32'h00000001, 32'h00000001, 1'b0, 32'h00000000, 4'b0000); // 16: denormals flushed
      add_vec(32'h80000000, 32'h00000000, 1'b0, 32'h00000000, 4'b0000); // 17: -0 + +0
      add_vec(32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 4'b0000); // 18: -0 - +0

      #1 n_reset = 1'b0;
      repeat (3) @(negedge clk);
      n_reset = 1'b1;
      @(negedge clk);

      for (int i = 0; i < vecs.size(); i++) begin
         if (i == 4) stall(2);
         if (i == 8) bubble();
         issue(i);
      end
      drain();

      for (int i = 0; i < 6; i++) issue(i);
      @(negedge clk);
      in_valid = 1'b0;
      n_reset = 1'b0;
      #1;
      check("async_reset", {out_valid, ovf, unf, inexact, invalid, result}, 37'd0);
      sb.delete();
      repeat (2) @(negedge clk);
      n_reset = 1'b1;
      repeat (6) @(negedge clk);

      h_valid = 1'b1; h_a = 16'h3C00; h_b = 16'h3C00; h_sub = 1'b0;
      cnt = 0;
      while (!h_ov && cnt < 10) begin
         @(posedge clk);
         #1;
         cnt++;
         h_valid = 1'b0;
      end
      check_int("half_latency", cnt, 4);
      check("half_result", {16'd0, h_ov, h_ovf, h_unf, h_inx, h_inv, h_res},
            {16'd0, 1'b1, 4'b0000, 16'h4000});
      repeat (2) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/fp_add_pipe.md
Name: fp_add_pipe

Overview:
Parametrised, fully pipelined IEEE-754-style floating-point adder/subtractor with round-to-nearest-even. It accepts one operation per enabled cycle and returns the result a fixed 3 enabled cycles later with valid and exception flags. It is the next-generation adder for the FFT butterfly datapath. Exponent and mantissa widths are generic, and subtract mode, special values and normalisation in either direction are handled in a single pass.

Parameters:
EXP_W, 8, exponent field width (≥3)
MAN_W, 23, stored fraction width, hidden bit excluded (≥4)
(derived) W = 1+EXP_W+MAN_W, BIAS = 2^(EXP_W-1)-1

Ports:
clk  in  1  clock, rising edge
n_reset  in  1  asynchronous active-low reset
clk_en  in  1  pipeline advance enable; low = whole pipe holds
in_valid  in  1  operands present this cycle
op_sub  in  1  1 = a-b, 0 = a+b
a  in  W  operand A {sign, exp, frac}
b  in  W  operand B
out_valid  out  1  result/flags valid
result  out  W  rounded sum/difference
ovf  out  1  result rounded to ±infinity from finite operands
unf  out  1  nonzero exact result flushed to zero
inexact  out  1  rounding discarded nonzero bits
invalid  out  1  inf-inf or NaN operand; result = canonical NaN

Behaviour:
- Reset (n_reset low, async): all pipeline registers cleared. out_valid, result, ovf, unf, inexact, invalid = 0. Operations in flight are discarded. No output pulse after release.
- No gated clock: every register updates only on posedge clk with clk_en=1. With clk_en=0, all stages and outputs hold, including out_valid.
- Latency: op sampled on enabled edge k → out_valid/result on enabled edge k+3. Throughput: 1 op per enabled cycle. in_valid=0 bubbles propagate as out_valid=0. When out_valid=0, result/flags are 0.
- Operand decode: effective sign of b is b[W-1]^op_sub.
  - exp==0 → zero (denormals flushed to ±0, no flag).
  - exp all-ones, frac==0 → ±inf; frac!=0 → NaN.
- Stage 1 (align):
  - Swap operands so the larger magnitude {exp,frac} is X; equal magnitude keeps a as X.
  - Shift d = eX-eY. Right-shift Y's {1,frac} by d into a (MAN_W+4)-bit field: hidden bit, MAN_W frac bits, guard, round, sticky. Sticky = OR of all bits shifted past it.
  - If d ≥ MAN_W+3, Y contributes only sticky = 1 (0 if Y is zero).
- Stage 2 (add/sub): effective add when signs equal, else X-Y. The result is MAN_W+5 bits wide with a carry bit. Result sign = sign of X.
- Stage 3 (normalise + round):
  - Carry set → shift right 1, OR the shifted-out bit into sticky, exp+1.
  - Otherwise, leading-zero count L → shift left L, exp-L. One MSB-seek priority encoder sized by MAN_W.
  - RNE: increment when G & (R|S|LSB). A mantissa carry from rounding → exp+1, frac=0.
- Exponent boundaries:
  - Final exp ≥ all-ones → ±inf, ovf=1, inexact=1.
  - Final exp ≤ 0 with nonzero mantissa → ±0, unf=1, inexact=1.
- Exact-zero result: +0, except -0 when both effective operand signs are negative.
- Special values:
  - Any NaN → canonical NaN (sign 0, exp all-ones, frac MSB=1, rest 0), invalid=1.
  - inf + (-inf) → canonical NaN, invalid=1.
  - inf ± finite → that inf, no flags.
  - X finite, Y zero → X exact.
  - Special results bypass rounding but follow the same 3-cycle latency.
- Flags are per-result, not sticky. They are valid only with out_valid.

Test Plan:
- 1.0+1.0: a=0x3F800000, b=0x3F800000, op_sub=0, in_valid pulse → exactly 3 enabled edges later out_valid=1, result=0x40000000, all flags 0.
- Cancellation and normalise-left:
  - 1.0-1.0 → 0x00000000.
  - 0x3F800001 - 0x3F800000 → 0x34000000 (2^-23), inexact=0.
  - (-0)+(-0) → 0x80000000.
- Rounding:
  - 0x3F800000 + 0x33800000 (exact tie) → 0x3F800000, inexact=1.
  - 0x3F800000 + 0x33800001 → 0x3F800001, inexact=1.
  - 0x3F800000 + 0x00800000 (d ≥ MAN_W+3) → 0x3F800000, inexact=1.
- Overflow and specials:
  - 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000, ovf=1.
  - 0x7F800000 - 0x7F800000 → 0x7FC00000, invalid=1.
  - 0x7FC00001 + 1.0 → 0x7FC00000, invalid=1.
- Streaming/stall: 8 back-to-back ops with clk_en toggled low for 2 cycles mid-stream → results in order, outputs frozen while clk_en=0, no lost/duplicated out_valid.
- Reset mid-flight: drop n_reset asynchronously with 3 ops in pipe → outputs 0 immediately. After release, no stale out_valid. Then rerun with EXP_W=5, MAN_W=10 (half precision): 0x3C00 + 0x3C00 → 0x4000.
